fb_conditioner: RTL and testbench

- Input-conditioning stage that sits directly upstream of the software PLL core's phase comparator and lockout logic.
- Takes the raw asynchronous feedback pin and produces a synchronized, deglitched feedback level plus single-cycle edge strobes.
- Also measures the rise-to-rise period in clk cycles, keeps a smoothed period for the display path, and flags loss of signal (LOS).
- The PLL core consumes fb, fb_rise and los; the display path consumes period_avg.

---
 rtl/fb_cond_pkg.sv | 19 +
 rtl/fb_deglitch.sv | 64 ++++++
 rtl/fb_conditioner.sv | 107 ++++++++++
 tb/tb_fb_conditioner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_cond_pkg.sv
// Shared constants for the PLL feedback conditioner.
// The LOS timeout is derived from the lowest feedback frequency the PLL must track.
package fb_cond_pkg;

  localparam int CLK_HZ       = 50_000_000;
  localparam int FREQ_MIN_HZ  = 50_000;

  // Two nominal periods of the slowest legal feedback, in clk cycles.
  function automatic int los_cycles_for(input int freq_min_hz);
    return (2 * CLK_HZ) / freq_min_hz;
  endfunction

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int GLITCH_CYCLES_DEF = 8;
  localparam int PERIOD_W_DEF      = 16;
  localparam int LOS_CYCLES_DEF    = los_cycles_for(FREQ_MIN_HZ);
  localparam int AVG_SHIFT_DEF     = 2;

endpackage

// File: rtl/fb_deglitch.sv
// Synchronizer plus level-persistence filter for the raw feedback pin.
// fb follows the synchronized input only after it has held a new level GLITCH_CYCLES cycles.
module fb_deglitch
  import fb_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int GLITCH_CYCLES = GLITCH_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fb_u,
  output logic fb,
  output logic fb_rise,
  output logic fb_fall
);

  localparam int CNT_W = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   fb_s;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   fb_reg;
  logic                   rise_reg;
  logic                   fall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], fb_u};
    end
  end

  assign fb_s = sync_reg[SYNC_STAGES-1];

  // Strobes are registered alongside fb so they coincide with its first new-value cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      fb_reg   <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else if (fb_s == fb_reg) begin
      cnt_reg  <= '0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg  <= '0;
      fb_reg   <= fb_s;
      rise_reg <= fb_s;
      fall_reg <= ~fb_s;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end
  end

  assign fb      = fb_reg;
  assign fb_rise = rise_reg;
  assign fb_fall = fall_reg;

endmodule

// File: rtl/fb_conditioner.sv
// Feedback conditioner: deglitched level and strobes, rise-to-rise period,
// exponentially smoothed period and loss-of-signal detection.
module fb_conditioner
  import fb_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int GLITCH_CYCLES = GLITCH_CYCLES_DEF,
  parameter int PERIOD_W      = PERIOD_W_DEF,
  parameter int LOS_CYCLES    = LOS_CYCLES_DEF,
  parameter int AVG_SHIFT     = AVG_SHIFT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fb_u,
  output logic                fb,
  output logic                fb_rise,
  output logic                fb_fall,
  output logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] period_avg,
  output logic                period_valid,
  output logic                los
);

  localparam logic [PERIOD_W-1:0] CTR_MAX  = '1;
  localparam logic [PERIOD_W-1:0] LOS_LAST = PERIOD_W'(LOS_CYCLES - 1);

  logic [PERIOD_W-1:0] ctr_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] avg_reg;
  logic                valid_reg;
  logic                los_reg;
  logic                armed_reg;
  logic                avg_loaded_reg;

  logic [PERIOD_W-1:0]      period_next;
  logic signed [PERIOD_W:0] avg_diff;
  logic signed [PERIOD_W:0] avg_step;
  logic signed [PERIOD_W:0] avg_sum;
  logic [PERIOD_W-1:0]      avg_next;
  logic                     capture;

  fb_deglitch #(
    .SYNC_STAGES   (SYNC_STAGES),
    .GLITCH_CYCLES (GLITCH_CYCLES)
  ) u_deglitch (
    .clk     (clk),
    .rst_n   (rst_n),
    .fb_u    (fb_u),
    .fb      (fb),
    .fb_rise (fb_rise),
    .fb_fall (fb_fall)
  );

  // The sum always lies between the old average and the new sample, so it fits PERIOD_W bits.
  always_comb begin
    period_next = (ctr_reg == CTR_MAX) ? CTR_MAX : ctr_reg + 1'b1;
    avg_diff    = $signed({1'b0, period_next}) - $signed({1'b0, avg_reg});
    avg_step    = avg_diff >>> AVG_SHIFT;
    avg_sum     = $signed({1'b0, avg_reg}) + avg_step;
    avg_next    = avg_sum[PERIOD_W-1:0];
    capture     = fb_rise & armed_reg & ~los_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_reg <= '0;
    end else if (fb_rise) begin
      ctr_reg <= '0;
    end else if (ctr_reg != CTR_MAX) begin
      ctr_reg <= ctr_reg + 1'b1;
    end
  end

  // A rise in the LOS threshold cycle takes priority over declaring loss of signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_reg     <= '0;
      avg_reg        <= '0;
      valid_reg      <= 1'b0;
      los_reg        <= 1'b1;
      armed_reg      <= 1'b0;
      avg_loaded_reg <= 1'b0;
    end else begin
      valid_reg <= capture;
      if (fb_rise) begin
        los_reg <= 1'b0;
        if (capture) begin
          period_reg     <= period_next;
          avg_reg        <= avg_loaded_reg ? avg_next : period_next;
          avg_loaded_reg <= 1'b1;
        end else begin
          armed_reg      <= 1'b1;
          avg_loaded_reg <= 1'b0;
        end
      end else if (ctr_reg == LOS_LAST) begin
        los_reg   <= 1'b1;
        armed_reg <= 1'b0;
      end
    end
  end

  assign period       = period_reg;
  assign period_avg   = avg_reg;
  assign period_valid = valid_reg;
  assign los          = los_reg;

endmodule

// File: tb/tb_fb_conditioner.sv
// Directed bench for fb_conditioner; expected period/average pairs are queued
// by the stimulus and checked by an independent monitor on period_valid.
module tb_fb_conditioner;

  localparam int PW   = 16;
  localparam int LOSC = 2000;
  localparam int LAT  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fb_u = 1'b0;
  logic          fb;
  logic          fb_rise;
  logic          fb_fall;
  logic [PW-1:0] period;
  logic [PW-1:0] period_avg;
  logic          period_valid;
  logic          los;

  always #10 clk = ~clk;

  fb_conditioner #(
    .SYNC_STAGES   (2),
    .GLITCH_CYCLES (8),
    .PERIOD_W      (PW),
    .LOS_CYCLES    (LOSC),
    .AVG_SHIFT     (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fb_u         (fb_u),
    .fb           (fb),
    .fb_rise      (fb_rise),
    .fb_fall      (fb_fall),
    .period       (period),
    .period_avg   (period_avg),
    .period_valid (period_valid),
    .los          (los)
  );

  typedef struct {
    logic [PW-1:0] p;
    logic [PW-1:0] a;
  } exp_t;

  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  int   hi_cnt = 0;
  int   valid_cnt = 0;
  int   last_rise_cyc = 0;
  int   los_set_cyc = -1;
  int   drv_cyc = 0;
  logic los_prev = 1'b1;
  logic los_at_first_rise = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: counts strobes, timestamps events and scores every period_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_rise) begin
        if (rise_cnt == 0) los_at_first_rise = los;
        rise_cnt++;
        last_rise_cyc = cyc;
      end
      if (fb_fall) fall_cnt++;
      if (fb) hi_cnt++;
      if (los && !los_prev) los_set_cyc = cyc;
      if (period_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual period=%0d avg=%0d required none", period, period_avg);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("period", 32'(period), 32'(e.p));
          check("period_avg", 32'(period_avg), 32'(e.a));
        end
      end
    end
    los_prev = los;
  end

  // Called aligned 1 time unit after a rising edge; leaves the bench aligned the same way.
  task automatic drive(input logic v, input int n);
    if (v && !fb_u) drv_cyc = cyc;
    fb_u = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int n, input int per, input int hi);
    repeat (n) begin
      drive(1'b1, hi);
      drive(1'b0, per - hi);
    end
  endtask

  task automatic push(input int p, input int a);
    exp_t e;
    e.p = PW'(p);
    e.a = PW'(a);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_fb"}, 32'(fb), 0);
    check({tag, "_los"}, 32'(los), 1);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_period_avg"}, 32'(period_avg), 0);
    check({tag, "_period_valid"}, 32'(period_valid), 0);
  endtask

  initial begin
    int vc;
    int rc;
    int fc;
    int waited;

    // Reset held with the pin toggling.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fb_u = ~fb_u;
    end
    @(negedge clk);
    check_reset_state("rst");
    check("rst_fb_rise", 32'(fb_rise), 0);
    @(posedge clk);
    #1;
    fb_u  = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 20);
    check("los_after_release", 32'(los), 1);

    // 400-cycle wave then a step to 500 cycles.
    push(400, 400);
    push(400, 400);
    push(400, 400);
    push(500, 425);
    push(500, 443);
    push(500, 457);
    push(500, 467);
    drive(1'b1, 200);
    check("fb_latency", 32'(last_rise_cyc - drv_cyc), LAT);
    check("first_rise_count", 32'(rise_cnt), 1);
    check("los_before_first_rise", 32'(los_at_first_rise), 1);
    check("los_after_first_rise", 32'(los), 0);
    check("no_valid_first_rise", 32'(valid_cnt), 0);
    drive(1'b0, 200);
    wave(2, 400, 200);
    wave(5, 500, 250);
    check("valid_count_step", 32'(valid_cnt), 7);

    // Loss of signal with the pin held low.
    waited = 0;
    while (!los && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("los_asserted", 32'(los), 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    // First sampled high once LOSC full cycles have elapsed after the strobe cycle.
    check("los_delay", 32'(los_set_cyc - last_rise_cyc), LOSC + 1);

    // Glitch rejection; the accepted pulse is also the rise that clears LOS.
    rc = rise_cnt;
    fc = fall_cnt;
    vc = valid_cnt;
    drive(1'b1, 7);
    drive(1'b0, 50);
    check("glitch7_rises", 32'(rise_cnt - rc), 0);
    check("glitch7_falls", 32'(fall_cnt - fc), 0);
    check("glitch7_fb", 32'(fb), 0);
    check("glitch7_los", 32'(los), 1);
    hi_cnt = 0;
    push(400, 400);
    drive(1'b1, 8);
    drive(1'b0, 392);
    check("glitch8_rises", 32'(rise_cnt - rc), 1);
    check("glitch8_falls", 32'(fall_cnt - fc), 1);
    check("glitch8_high_cycles", 32'(hi_cnt), 8);
    check("los_cleared", 32'(los), 0);
    check("no_valid_rearm", 32'(valid_cnt - vc), 0);
    drive(1'b1, 200);
    drive(1'b0, 200);
    check("valid_after_rearm", 32'(valid_cnt - vc), 1);

    // Reset 250 cycles into a period.
    vc = valid_cnt;
    push(400, 400);
    drive(1'b1, 200);
    drive(1'b0, 50);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 97);
    push(400, 400);
    push(400, 400);
    wave(3, 400, 200);
    check("valid_after_midrst", 32'(valid_cnt - vc), 3);
    check("los_after_midrst", 32'(los), 0);

    drive(1'b0, 20);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
